// File: rtl/servo_pkg.sv
// Shared constants, state encoding and range helper for the servo ramp controller.
package servo_pkg;

    localparam int unsigned DEF_FRAME_CYCLES = 2000000;
    localparam int unsigned DEF_MIN_PULSE    = 50000;
    localparam int unsigned DEF_MAX_PULSE    = 100000;
    localparam int unsigned DEF_RESET_PULSE  = 75000;

    localparam int unsigned PULSE_W = 32;
    localparam int unsigned STEP_W  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } servo_state_e;

    function automatic logic [PULSE_W-1:0] clamp(
        input logic [PULSE_W-1:0] value,
        input logic [PULSE_W-1:0] lo,
        input logic [PULSE_W-1:0] hi
    );
        if (value < lo) begin
            return lo;
        end else if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running PWM frame counter; frame_start is high for the whole last cycle of each frame.
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES
) (
    input  logic clock_clk,
    input  logic reset,
    output logic frame_start,
    output logic last_next_c
);

    localparam int unsigned CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt_c;

    // Look one count ahead so the strobe can be registered yet land on the boundary cycle.
    always_comb begin
        count_nxt_c = (count_q == LAST) ? '0 : count_q + CW'(1);
        last_next_c = (count_nxt_c == LAST);
    end

    always_ff @(posedge clock_clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            frame_start <= 1'b0;
        end else begin
            count_q     <= count_nxt_c;
            frame_start <= last_next_c;
        end
    end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Slew-limited servo position controller: clamps commanded targets and steps pulse_time
// toward them by at most step_size per PWM frame, updating only on frame boundaries.
module servo_ramp_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int unsigned MIN_PULSE    = DEF_MIN_PULSE,
    parameter int unsigned MAX_PULSE    = DEF_MAX_PULSE,
    parameter int unsigned RESET_PULSE  = DEF_RESET_PULSE
) (
    input  logic        clock_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_target,
    input  logic [15:0] step_size,
    output logic [31:0] pulse_time,
    output logic        frame_start,
    output logic        busy,
    output logic        done
);

    localparam logic [PULSE_W-1:0] MIN_P   = PULSE_W'(MIN_PULSE);
    localparam logic [PULSE_W-1:0] MAX_P   = PULSE_W'(MAX_PULSE);
    localparam logic [PULSE_W-1:0] RESET_P = PULSE_W'(RESET_PULSE);

    servo_state_e         state_q;
    logic [PULSE_W-1:0]   target_q;
    logic [PULSE_W-1:0]   pos_q;

    logic                 last_next_c;
    logic                 cmd_fire_c;
    logic                 step_now_c;
    logic                 reach_c;
    logic [PULSE_W-1:0]   clamped_c;
    logic signed [PULSE_W:0] diff_c;
    logic [PULSE_W:0]     mag_c;
    logic [PULSE_W-1:0]   pos_step_c;
    logic [PULSE_W-1:0]   pos_nxt_c;

    servo_frame_timer #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_frame_timer (
        .clock_clk  (clock_clk),
        .reset      (reset),
        .frame_start(frame_start),
        .last_next_c(last_next_c)
    );

    // Step arithmetic; frame_start doubles as the boundary-cycle indicator.
    always_comb begin
        clamped_c  = clamp(cmd_target, MIN_P, MAX_P);
        cmd_fire_c = cmd_valid && cmd_ready;
        diff_c     = $signed({1'b0, target_q}) - $signed({1'b0, pos_q});
        mag_c      = diff_c[PULSE_W] ? $unsigned(-diff_c) : $unsigned(diff_c);
        reach_c    = (step_size == '0) || (mag_c <= (PULSE_W+1)'(step_size));
        if (reach_c) begin
            pos_step_c = target_q;
        end else if (diff_c[PULSE_W]) begin
            pos_step_c = pos_q - PULSE_W'(step_size);
        end else begin
            pos_step_c = pos_q + PULSE_W'(step_size);
        end
        step_now_c = frame_start && enable && (state_q == RAMP);
        pos_nxt_c  = step_now_c ? pos_step_c : pos_q;
    end

    always_ff @(posedge clock_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            target_q   <= RESET_P;
            pos_q      <= RESET_P;
            pulse_time <= RESET_P;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            cmd_ready  <= !last_next_c;
            done       <= 1'b0;
            pos_q      <= pos_nxt_c;
            // A limp servo sees zero width; the position register itself holds.
            pulse_time <= enable ? pos_nxt_c : '0;
            if (step_now_c) begin
                if (reach_c) begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
            end else if (cmd_fire_c) begin
                target_q <= clamped_c;
                if ((state_q == IDLE) && (clamped_c != pos_q)) begin
                    state_q <= RAMP;
                    busy    <= 1'b1;
                end
            end
        end
    end

endmodule
